// File: rtl/axi_sync_framer_pkg.sv
// Shared types and widths for the sync-word framer.
// Imported by the framer top and the bench.
package rwt_framer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } framer_state_t;

  localparam int MISS_W = 16;
  localparam int FLEN_W = 16;

  // a frame needs at least the sync beat plus one payload beat
  function automatic logic [FLEN_W-1:0] clamp_flen(
    input logic [FLEN_W-1:0] len
  );
    return (len < FLEN_W'(2)) ? FLEN_W'(2) : len;
  endfunction

endpackage

// File: rtl/axi_sync_framer_if.sv
// Valid/ready stream bundle: data plus {last, user}.
// Master drives the beat, slave drives ready.
interface axi_sync_framer_if #(
  parameter int DWIDTH = 64,
  parameter int UWIDTH = 8
);
  logic              valid;
  logic              ready;
  logic [DWIDTH-1:0] data;
  logic [UWIDTH:0]   user;

  modport master (output valid, data, user, input ready);
  modport slave  (input valid, data, user, output ready);
endinterface

// File: rtl/axi_sync_framer_oreg.sv
// One-entry output register of the framer.
// Holds a beat until the sink takes it; reset discards it.
module axi_framer_oreg #(
  parameter int DWIDTH = 64,
  parameter int UWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic [UWIDTH:0]   user_i,
  output logic              free_o,
  axi_sync_framer_if.master m
);

  logic              valid_q;
  logic              valid_d;
  logic [DWIDTH-1:0] data_q;
  logic [UWIDTH:0]   user_q;

  assign free_o = !valid_q || m.ready;

  // slot fills on load, empties when the sink takes it
  always_comb begin
    valid_d = valid_q;
    if (load_i)
      valid_d = 1'b1;
    else if (m.ready)
      valid_d = 1'b0;
  end

  // valid flag, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      valid_q <= 1'b0;
    else
      valid_q <= valid_d;
  end

  // payload needs no reset; only written when free
  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
      user_q <= user_i;
    end
  end

  assign m.valid = valid_q;
  assign m.data  = data_q;
  assign m.user  = user_q;

endmodule

// File: rtl/axi_sync_framer.sv
// Sync-word framer: searches, verifies and tracks frame
// alignment, forwarding payload beats with a regenerated last.
module axi_sync_framer
  import rwt_framer_pkg::*;
#(
  parameter int DWIDTH     = 64,
  parameter int UWIDTH     = 8,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              cfg_enable,
  input  logic [FLEN_W-1:0] cfg_frame_len,
  input  logic              s_axi_valid,
  output logic              s_axi_ready,
  input  logic [DWIDTH-1:0] s_axi_data,
  input  logic [UWIDTH:0]   s_axi_user,
  input  logic              s_axi_equal,
  output logic              m_axi_valid,
  input  logic              m_axi_ready,
  output logic [DWIDTH-1:0] m_axi_data,
  output logic [UWIDTH:0]   m_axi_user,
  output logic              locked,
  output logic [1:0]        state,
  output logic [MISS_W-1:0] miss_cnt
);

  framer_state_t     state_q, state_d;
  logic [FLEN_W-1:0] pos_q, pos_d;
  logic [FLEN_W-1:0] flen_q, flen_d;
  logic [3:0]        hits_q, hits_d;
  logic [3:0]        misses_q, misses_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;

  logic              acc;
  logic              free;
  logic              at_sync;
  logic              at_end;
  logic              hit_done;
  logic              miss_done;
  logic [FLEN_W-1:0] pos_nxt;
  logic              fwd;
  logic [UWIDTH:0]   fwd_user;
  logic              unused_last;

  axi_sync_framer_if #(
    .DWIDTH(DWIDTH),
    .UWIDTH(UWIDTH)
  ) out_if ();

  assign unused_last = s_axi_user[UWIDTH];
  assign s_axi_ready = free;
  assign acc         = s_axi_valid && free;
  assign at_sync     = (pos_q == '0);
  assign at_end      = (pos_q == flen_q - FLEN_W'(1));
  assign pos_nxt     = at_end ? '0 : pos_q + FLEN_W'(1);
  assign hit_done    = (hits_q + 4'd1) == 4'(LOCK_CNT);
  assign miss_done   = (misses_q + 4'd1) == 4'(UNLOCK_CNT);

  // state and counters
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      flen_q     <= FLEN_W'(2);
      hits_q     <= '0;
      misses_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      flen_q     <= flen_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // alignment decisions, taken on accepted beats only
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    flen_d     = flen_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable) begin
          state_d  = SEARCH;
          flen_d   = clamp_flen(cfg_frame_len);
          pos_d    = '0;
          hits_d   = '0;
          misses_d = '0;
        end
      end
      SEARCH: begin
        if (!cfg_enable) begin
          state_d = IDLE;
        end else if (acc && s_axi_equal) begin
          pos_d    = FLEN_W'(1);
          hits_d   = 4'd1;
          misses_d = '0;
          state_d  = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (!cfg_enable) begin
          state_d = IDLE;
        end else if (acc) begin
          pos_d = pos_nxt;
          if (at_sync && s_axi_equal) begin
            hits_d = hits_q + 4'd1;
            if (hit_done) begin
              state_d  = LOCKED;
              misses_d = '0;
            end
          end else if (at_sync) begin
            state_d = SEARCH;
            pos_d   = '0;
            hits_d  = '0;
          end
        end
      end
      LOCKED: begin
        if (acc) begin
          pos_d = pos_nxt;
          if (at_sync) begin
            if (!cfg_enable) begin
              state_d = IDLE;
              pos_d   = '0;
            end else if (s_axi_equal) begin
              misses_d = '0;
            end else begin
              misses_d = misses_q + 4'd1;
              if (miss_cnt_q != '1)
                miss_cnt_d = miss_cnt_q + MISS_W'(1);
              if (miss_done) begin
                state_d = SEARCH;
                pos_d   = '0;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // status and forwarding of payload beats
  always_comb begin
    locked   = (state_q == LOCKED);
    fwd      = acc && locked && !at_sync;
    fwd_user = {at_end, s_axi_user[UWIDTH-1:0]};
  end

  axi_framer_oreg #(
    .DWIDTH(DWIDTH),
    .UWIDTH(UWIDTH)
  ) u_oreg (
    .clk    (clk),
    .rst_n  (aresetn),
    .load_i (fwd),
    .data_i (s_axi_data),
    .user_i (fwd_user),
    .free_o (free),
    .m      (out_if.master)
  );

  assign m_axi_valid  = out_if.valid;
  assign m_axi_data   = out_if.data;
  assign m_axi_user   = out_if.user;
  assign out_if.ready = m_axi_ready;
  assign state        = state_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_axi_sync_framer.sv
// Bench for axi_sync_framer: frame-level model plus
// directed scenarios with literal expectations.
module tb_axi_sync_framer;
  import rwt_framer_pkg::*;

  localparam int DW = 64;
  localparam int UW = 8;
  localparam int LK = 3;
  localparam int UL = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [UW:0]   u;
  } beat_t;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [15:0]   cfg_frame_len = 16'd8;
  logic          s_equal = 1'b0;
  logic          m_ready = 1'b1;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [UW:0]   m_user;
  logic          locked;
  logic [1:0]    state;
  logic [15:0]   miss_cnt;

  axi_sync_framer_if #(.DWIDTH(DW), .UWIDTH(UW)) src ();

  axi_sync_framer #(
    .DWIDTH(DW), .UWIDTH(UW),
    .LOCK_CNT(LK), .UNLOCK_CNT(UL)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .cfg_enable(cfg_enable), .cfg_frame_len(cfg_frame_len),
    .s_axi_valid(src.valid), .s_axi_ready(src.ready),
    .s_axi_data(src.data), .s_axi_user(src.user),
    .s_axi_equal(s_equal),
    .m_axi_valid(m_valid), .m_axi_ready(m_ready),
    .m_axi_data(m_data), .m_axi_user(m_user),
    .locked(locked), .state(state), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // frame-level model
  int    m_state, m_pos, m_flen, m_hits, m_misses, m_miss;
  beat_t expq[$];
  beat_t got[$];
  beat_t ref_q[$];
  beat_t mon_b;
  logic  stall_prev;
  logic [DW-1:0] prev_d;

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_flen = 2;
    m_hits = 0; m_misses = 0; m_miss = 0;
    expq.delete();
    stall_prev = 1'b0;
  endtask

  task automatic model_step(input bit acc, input bit eq,
                            input beat_t b);
    int nxt;
    nxt = (m_pos + 1) % m_flen;
    case (m_state)
      0: if (cfg_enable) begin
        m_state = 1;
        m_flen = (cfg_frame_len < 2) ? 2 : int'(cfg_frame_len);
        m_pos = 0; m_hits = 0; m_misses = 0;
      end
      1: if (!cfg_enable) m_state = 0;
        else if (acc && eq) begin
          m_pos = 1; m_hits = 1; m_misses = 0;
          m_state = (LK == 1) ? 3 : 2;
        end
      2: if (!cfg_enable) m_state = 0;
        else if (acc) begin
          if (m_pos == 0 && !eq) begin
            m_state = 1; m_pos = 0;
          end else begin
            if (m_pos == 0) begin
              m_hits++;
              if (m_hits == LK) begin m_state = 3; m_misses = 0; end
            end
            m_pos = nxt;
          end
        end
      3: if (acc) begin
        if (m_pos != 0) begin
          b.u[UW] = (m_pos == m_flen - 1);
          expq.push_back(b);
          m_pos = nxt;
        end else if (!cfg_enable) begin
          m_state = 0; m_pos = 0;
        end else begin
          m_pos = nxt;
          if (eq) m_misses = 0;
          else begin
            m_misses++;
            if (m_miss < 65535) m_miss++;
            if (m_misses == UL) begin m_state = 1; m_pos = 0; end
          end
        end
      end
      default: ;
    endcase
  endtask

  // compare DUT against the model every cycle
  always @(negedge clk) begin
    if (!aresetn) model_reset();
    chk("state", 64'(state), 64'(m_state));
    chk("locked", 64'(locked), 64'(m_state == 3));
    chk("miss_cnt", 64'(miss_cnt), 64'(m_miss));
    chk("m_valid", 64'(m_valid), 64'(expq.size() != 0));
    if (m_valid && expq.size() != 0) begin
      chk("m_data", m_data, expq[0].d);
      chk("m_user", 64'(m_user), 64'(expq[0].u));
    end
    if (stall_prev && m_valid) chk("hold_data", m_data, prev_d);
    if (m_valid && m_ready) begin
      mon_b.d = m_data; mon_b.u = m_user;
      got.push_back(mon_b);
      if (expq.size() != 0) expq.delete(0);
    end
    stall_prev = m_valid && !m_ready;
    prev_d = m_data;
    if (aresetn) begin
      mon_b.d = src.data; mon_b.u = src.user;
      model_step(src.valid && src.ready, s_equal, mon_b);
    end
  end

  // sink: 0 always ready, 1 ready 1 of 5, 2 held low
  int tmode = 0;
  int cyc = 0;
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    m_ready = (tmode == 0) ? 1'b1 :
              (tmode == 1) ? (cyc % 5 == 0) : 1'b0;
  end

  function automatic logic [DW-1:0] bd(input int f, input int p);
    return 64'hA500_0000_0000_0000 | 64'(f * 16 + p);
  endfunction

  function automatic logic [UW:0] bu(input int f, input int p);
    logic [UW-1:0] u;
    u = 8'(f * 8 + p) ^ 8'h3C;
    return {1'($urandom_range(0, 1)), u};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d,
                           input logic [UW:0] u, input logic eq);
    bit ok;
    ok = 0;
    src.valid = 1'b1; src.data = d; src.user = u; s_equal = eq;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (src.ready) ok = 1;
    end
    @(posedge clk); #1;
    src.valid = 1'b0; s_equal = 1'b0;
    if (!ok) chk("accept_timeout", 64'(ok), 64'(1));
  endtask

  task automatic send_frame(input int f, input int fl, input bit sync);
    for (int p = 0; p < fl; p++)
      send_beat(bd(f, p), bu(f, p), (p == 0) && sync);
  endtask

  task automatic garbage(input int n);
    for (int i = 0; i < n; i++) send_beat(bd(99, i), bu(99, i), 1'b0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    idle(2);
    got.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish after 2ms");
    $fatal(1);
  end

  initial begin
    int n;
    src.valid = 1'b0; src.data = '0; src.user = '0;
    model_reset();
    @(negedge clk);
    chk("rst_state", 64'(state), 64'(0));
    chk("rst_valid", 64'(m_valid), 64'(0));
    chk("rst_miss", 64'(miss_cnt), 64'(0));
    @(posedge clk); #1 aresetn = 1'b1;
    idle(2);

    // clean sync every 8 beats
    cfg_frame_len = 16'd8; cfg_enable = 1'b1;
    garbage(3);
    for (int f = 0; f < 6; f++) send_frame(f, 8, 1);
    idle(10);
    chk("s1_state", 64'(state), 64'(3));
    chk("s1_count", 64'(got.size()), 64'(28));
    chk("s1_first", got[0].d, 64'hA500_0000_0000_0021);
    chk("s1_last7", 64'(got[6].u[UW]), 64'(1));
    chk("s1_nolast6", 64'(got[5].u[UW]), 64'(0));
    n = 0;
    foreach (got[i]) if (got[i].u[UW]) n++;
    chk("s1_lasts", 64'(n), 64'(4));
    ref_q = got;

    // missing syncs: one tolerated, two consecutive unlock
    do_reset();
    for (int f = 0; f < 8; f++) begin
      send_frame(f, 8, !(f == 4 || f == 6 || f == 7));
      if (f == 4) begin
        chk("s2_miss1", 64'(miss_cnt), 64'(1));
        chk("s2_held", 64'(state), 64'(3));
      end
    end
    idle(5);
    chk("s2_state", 64'(state), 64'(1));
    chk("s2_misscnt", 64'(miss_cnt), 64'(3));
    chk("s2_count", 64'(got.size()), 64'(35));

    // stray match mid-frame during verify, then missing sync
    do_reset();
    for (int p = 0; p < 8; p++) begin
      send_beat(bd(0, p), bu(0, p), p == 0 || p == 3);
      if (p == 3) chk("s3_verify", 64'(state), 64'(2));
    end
    send_beat(bd(1, 0), bu(1, 0), 1'b0);
    idle(3);
    chk("s3_state", 64'(state), 64'(1));
    chk("s3_count", 64'(got.size()), 64'(0));

    // throttled sink must see the same stream
    do_reset();
    tmode = 1;
    garbage(3);
    for (int f = 0; f < 6; f++) send_frame(f, 8, 1);
    idle(40);
    tmode = 0;
    chk("s4_count", 64'(got.size()), 64'(ref_q.size()));
    for (int i = 0; i < got.size() && i < ref_q.size(); i++) begin
      chk("s4_data", got[i].d, ref_q[i].d);
      chk("s4_user", 64'(got[i].u), 64'(ref_q[i].u));
    end

    // enable drop mid-frame, then short frame length
    do_reset();
    garbage(1);
    for (int f = 0; f < 3; f++) send_frame(f, 8, 1);
    for (int p = 0; p < 8; p++) begin
      if (p == 5) cfg_enable = 1'b0;
      send_beat(bd(3, p), bu(3, p), p == 0);
    end
    send_frame(4, 8, 1);
    idle(3);
    chk("s5_state", 64'(state), 64'(0));
    chk("s5_count", 64'(got.size()), 64'(14));
    chk("s5_last", 64'(got[13].u[UW]), 64'(1));
    cfg_frame_len = 16'd1; cfg_enable = 1'b1;
    garbage(1);
    cfg_frame_len = 16'd9;
    for (int f = 0; f < 5; f++) send_frame(f, 2, 1);
    idle(3);
    chk("s5_count2", 64'(got.size()), 64'(17));
    chk("s5_sdata", got[14].d, 64'hA500_0000_0000_0021);
    n = 0;
    for (int i = 14; i < got.size(); i++) if (got[i].u[UW]) n++;
    chk("s5_slasts", 64'(n), 64'(3));

    // reset while a beat is held
    cfg_frame_len = 16'd8;
    do_reset();
    garbage(1);
    for (int f = 0; f < 3; f++) send_frame(f, 8, 1);
    idle(3);
    tmode = 2;
    idle(2);
    send_beat(bd(3, 0), bu(3, 0), 1'b1);
    send_beat(bd(3, 1), bu(3, 1), 1'b0);
    idle(2);
    chk("s6_hold", 64'(m_valid), 64'(1));
    #3 aresetn = 1'b0;
    #1;
    chk("s6_valid", 64'(m_valid), 64'(0));
    chk("s6_idle", 64'(state), 64'(0));
    @(posedge clk); #1 aresetn = 1'b1;
    tmode = 0;
    idle(2);
    got.delete();
    send_frame(0, 8, 1);
    send_frame(1, 8, 1);
    chk("s6_verify", 64'(state), 64'(2));
    send_beat(bd(2, 0), bu(2, 0), 1'b1);
    chk("s6_relock", 64'(state), 64'(3));
    for (int p = 1; p < 8; p++) send_beat(bd(2, p), bu(2, p), 1'b0);
    idle(3);
    chk("s6_count", 64'(got.size()), 64'(7));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axi_sync_framer.md
AXI_SYNC_FRAMER -- requirements
Module: axi_sync_framer

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, data width in bits.
REQ-002 SHALL have parameter UWIDTH, default 8, user sideband width excluding last.
REQ-003 SHALL have parameter LOCK_CNT, default 3, consecutive sync hits required to lock (range 1..15).
REQ-004 SHALL have parameter UNLOCK_CNT, default 2, consecutive sync misses required to drop lock (range 1..15).
REQ-005 SHALL have ports: clk in 1, the single clock; aresetn in 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports: cfg_enable in 1, framer enable; cfg_frame_len in 16, beats per frame including the sync beat.
REQ-007 SHALL have ports: s_axi_valid in 1; s_axi_ready out 1; s_axi_data in DWIDTH; s_axi_user in UWIDTH+1, {last, user}; s_axi_equal in 1, sync-word match flag aligned to the beat.
REQ-008 SHALL have ports: m_axi_valid out 1; m_axi_ready in 1; m_axi_data out DWIDTH; m_axi_user out UWIDTH+1, {last, user}.
REQ-009 SHALL have ports: locked out 1; state out 2; miss_cnt out 16, saturating count of sync misses while locked.

Function
REQ-010 SHALL implement states IDLE=0, SEARCH=1, VERIFY=2, LOCKED=3.
REQ-011 SHALL treat an input beat as accepted only on s_axi_valid && s_axi_ready, and SHALL take every state/counter decision on accepted beats only.
REQ-012 SHALL drive s_axi_ready = !m_axi_valid || m_axi_ready in all states, dropped beats included.
REQ-013 SHALL keep a beat position counter pos, 0 = expected sync beat, wrapping from flen-1 to 0.
REQ-014 SHALL latch flen = max(cfg_frame_len, 2) on leaving IDLE; later cfg_frame_len changes SHALL have no effect until IDLE is re-entered.
REQ-015 IDLE: SHALL drop all beats; SHALL go to SEARCH when cfg_enable=1.
REQ-016 SEARCH: SHALL drop beats; on a beat with s_axi_equal=1, SHALL set pos=1, hits=1, and go to LOCKED if LOCK_CNT=1, else VERIFY.
REQ-017 VERIFY: SHALL drop beats; at pos=0 with equal=1, SHALL increment hits and go to LOCKED when hits reaches LOCK_CNT; at pos=0 with equal=0, SHALL return to SEARCH; equal=1 at pos!=0 SHALL be ignored.
REQ-018 LOCKED: SHALL forward beats at pos 1..flen-1 with data/user unchanged except m_axi_user[UWIDTH] (last) = 1 exactly at pos=flen-1; SHALL drop the pos=0 beat.
REQ-019 LOCKED, pos=0: equal=1 SHALL clear misses; equal=0 SHALL increment misses and miss_cnt (saturate at 16'hFFFF); misses reaching UNLOCK_CNT SHALL go to SEARCH on that beat.
REQ-020 Input last bit SHALL be ignored for framing decisions.
REQ-021 cfg_enable=0 SHALL force IDLE on the next clock from SEARCH/VERIFY, and from LOCKED only on the next accepted pos=0 beat, so that no partial frame is emitted.
REQ-022 locked SHALL be 1 exactly when state=LOCKED.
REQ-023 Forward latency SHALL be one clock: a beat accepted at edge N appears on m_axi_* after edge N.
REQ-024 m_axi_valid SHALL hold and m_axi_data/user SHALL be stable while m_axi_valid && !m_axi_ready.
REQ-025 An accepted beat at pos=0 with equal=0 SHALL still advance pos (flywheel), with no resync inside LOCKED.

Reset
REQ-026 aresetn=0 SHALL asynchronously force state=IDLE, pos=0, hits=0, misses=0, miss_cnt=0, m_axi_valid=0, locked=0, flen=2.
REQ-027 m_axi_data/user need not be reset.
REQ-028 Reset mid-frame SHALL discard the held output beat, with no last emitted.

Structure
REQ-029 Package rwt_framer_pkg SHALL hold the state enum typedef framer_state_t and the widths of miss_cnt and cfg_frame_len.
REQ-030 The one-entry output register SHALL be a sub-module axi_framer_oreg (valid/ready/data/user, async active-low reset).
REQ-031 The state machine and counters SHALL reside in axi_sync_framer; total RTL 120-400 lines.

Verification
REQ-032 flen=8, LOCK_CNT=3, sync (equal=1) every 8 beats, no throttle -> locked after the 3rd sync beat; subsequent frames output 7 beats each, last only on the 7th.
REQ-033 Same as REQ-032 with one sync missing -> still locked, miss_cnt=1, beats still forwarded; two consecutive misses -> state=SEARCH at the 2nd miss, no further output.
REQ-034 equal=1 at pos 3 during VERIFY -> ignored; equal=0 at the next pos 0 -> state returns to SEARCH, zero output beats.
REQ-035 Sink throttled (m_axi_ready low 4 of every 5 cycles, as file_sink throttle 5) -> output bytes identical to the unthrottled run, no beat lost or duplicated, data stable while stalled.
REQ-036 cfg_enable drop at pos 4 while locked -> frame completes with last, next sync dropped, state=IDLE; cfg_frame_len=1 -> treated as flen=2.
REQ-037 aresetn pulse while m_axi_valid=1 mid-frame -> m_axi_valid=0 and state=IDLE immediately; relock needs LOCK_CNT syncs again.
